operand_fetch_stage: RTL

// - Decode/operand-fetch stage directly upstream of RegisterFile.
// - Drives RegisterFile read addresses from the incoming instruction and captures ReadData1/ReadData2.
// - Bypasses same-cycle writeback data, since RegisterFile re-reads only when an address changes.
// - Registers decoded fields into the ID/EX boundary with a valid/ready handshake and inserts load-use bubbles.
//

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/operand_fetch_stage_if.sv | 27 ++
 rtl/operand_fetch_stage_bypass.sv | 22 ++
 rtl/operand_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode constants, field slices and decode helpers
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic {
    LU_CLEAR = 1'b0,
    LU_ARMED = 1'b1
  } lu_state_e;

  function automatic logic writes_reg(input logic [5:0] op);
    logic w;
    case (op)
      OP_RTYPE, OP_LW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: w = 1'b1;
      default:                                                    w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - ID/EX bundle with valid/ready handshake
interface operand_fetch_stage_if #(
  parameter int DW = 32
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_rs_data;
  logic [DW-1:0] out_rt_data;
  logic [DW-1:0] out_imm;
  logic [5:0]    out_opcode;
  logic [5:0]    out_funct;
  logic [4:0]    out_dest;
  logic          out_reg_write;
  logic          out_mem_read;

  modport master (
    output out_valid, out_rs_data, out_rt_data, out_imm, out_opcode,
           out_funct, out_dest, out_reg_write, out_mem_read,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_rs_data, out_rt_data, out_imm, out_opcode,
           out_funct, out_dest, out_reg_write, out_mem_read,
    output out_ready
  );
endinterface

// File: rtl/operand_fetch_stage_bypass.sv
// rtl/operand_fetch_stage_bypass.sv - one read port: $zero, writeback bypass or RF data
module operand_bypass #(
  parameter int DW = 32
) (
  input  logic [4:0]    reg_addr_i,
  input  logic [DW-1:0] rf_data_i,
  input  logic          wb_reg_write_i,
  input  logic [4:0]    wb_write_reg_i,
  input  logic [DW-1:0] wb_write_data_i,
  output logic [DW-1:0] operand_o
);

  always_comb begin
    operand_o = rf_data_i;
    if (reg_addr_i == 5'd0) begin
      operand_o = '0;
    end else if (wb_reg_write_i && (wb_write_reg_i == reg_addr_i)) begin
      operand_o = wb_write_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - decode/operand fetch into the ID/EX register
// with writeback bypass, held-bundle snooping and load-use bubble insertion.
module operand_fetch_stage
  import mips_pkg::*;
#(
  parameter int LU_STALL = 1,
  parameter int DW       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic                  flush,
  output logic [4:0]            rf_read_reg1,
  output logic [4:0]            rf_read_reg2,
  input  logic [DW-1:0]         rf_read_data1,
  input  logic [DW-1:0]         rf_read_data2,
  input  logic                  wb_reg_write,
  input  logic [4:0]            wb_write_reg,
  input  logic [DW-1:0]         wb_write_data,
  operand_fetch_stage_if.master ex
);

  localparam logic [1:0] LU_STALL_CNT = 2'(LU_STALL);

  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [5:0]    funct;
  logic [DW-1:0] imm_ext;
  logic [4:0]    dest;
  logic [DW-1:0] rs_operand;
  logic [DW-1:0] rt_operand;

  logic          valid_q, valid_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [5:0]    opcode_q, opcode_d;
  logic [5:0]    funct_q, funct_d;
  logic [4:0]    dest_q, dest_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic [4:0]    rs_q, rs_d;
  logic [4:0]    rt_q, rt_d;

  lu_state_e     lu_state_q, lu_state_d;
  logic [1:0]    lu_cnt_q, lu_cnt_d;
  logic [4:0]    lu_dest_q, lu_dest_d;

  logic          hazard;
  logic          accept;
  logic          consume;

  assign opcode  = in_instr[OP_MSB:OP_LSB];
  assign rs      = in_instr[RS_MSB:RS_LSB];
  assign rt      = in_instr[RT_MSB:RT_LSB];
  assign rd      = in_instr[RD_MSB:RD_LSB];
  assign funct   = in_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm_ext = {{(DW-16){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};
  assign dest    = (opcode == OP_RTYPE) ? rd : rt;

  assign rf_read_reg1 = rs;
  assign rf_read_reg2 = rt;

  operand_bypass #(.DW(DW)) u_bypass_rs (
    .reg_addr_i      (rs),
    .rf_data_i       (rf_read_data1),
    .wb_reg_write_i  (wb_reg_write),
    .wb_write_reg_i  (wb_write_reg),
    .wb_write_data_i (wb_write_data),
    .operand_o       (rs_operand)
  );

  operand_bypass #(.DW(DW)) u_bypass_rt (
    .reg_addr_i      (rt),
    .rf_data_i       (rf_read_data2),
    .wb_reg_write_i  (wb_reg_write),
    .wb_write_reg_i  (wb_write_reg),
    .wb_write_data_i (wb_write_data),
    .operand_o       (rt_operand)
  );

  // rt is compared even for opcodes that do not read it; a spare bubble is cheaper than a decode.
  assign hazard = (lu_state_q == LU_ARMED) && in_valid && (lu_dest_q != 5'd0) &&
                  ((rs == lu_dest_q) || (rt == lu_dest_q));

  assign in_ready = !reset && !flush && !hazard && (!valid_q || ex.out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && ex.out_ready;

  always_comb begin
    valid_d     = valid_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    opcode_d    = opcode_q;
    funct_d     = funct_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      rs_data_d   = rs_operand;
      rt_data_d   = rt_operand;
      imm_d       = imm_ext;
      opcode_d    = opcode;
      funct_d     = funct;
      dest_d      = dest;
      reg_write_d = writes_reg(opcode);
      mem_read_d  = (opcode == OP_LW);
      rs_d        = rs;
      rt_d        = rt;
    end else if (consume) begin
      valid_d = 1'b0;
    end else begin
      // RegisterFile output would be stale for a held bundle, so catch writes here.
      if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rs_q)) begin
        rs_data_d = wb_write_data;
      end
      if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == rt_q)) begin
        rt_data_d = wb_write_data;
      end
    end
  end

  always_comb begin
    lu_state_d = lu_state_q;
    lu_cnt_d   = lu_cnt_q;
    lu_dest_d  = lu_dest_q;
    if (flush) begin
      lu_state_d = LU_CLEAR;
      lu_cnt_d   = 2'd0;
    end else if (consume && mem_read_q && (dest_q != 5'd0)) begin
      lu_state_d = LU_ARMED;
      lu_cnt_d   = LU_STALL_CNT;
      lu_dest_d  = dest_q;
    end else begin
      case (lu_state_q)
        LU_ARMED: begin
          lu_cnt_d   = lu_cnt_q - 2'd1;
          lu_state_d = (lu_cnt_q == 2'd1) ? LU_CLEAR : LU_ARMED;
        end
        default: begin
          lu_state_d = LU_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      opcode_q    <= '0;
      funct_q     <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      lu_state_q  <= LU_CLEAR;
      lu_cnt_q    <= 2'd0;
      lu_dest_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      opcode_q    <= opcode_d;
      funct_q     <= funct_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      lu_state_q  <= lu_state_d;
      lu_cnt_q    <= lu_cnt_d;
      lu_dest_q   <= lu_dest_d;
    end
  end

  assign ex.out_valid     = valid_q;
  assign ex.out_rs_data   = rs_data_q;
  assign ex.out_rt_data   = rt_data_q;
  assign ex.out_imm       = imm_q;
  assign ex.out_opcode    = opcode_q;
  assign ex.out_funct     = funct_q;
  assign ex.out_dest      = dest_q;
  assign ex.out_reg_write = reg_write_q;
  assign ex.out_mem_read  = mem_read_q;

endmodule
